// File: rtl/core_trace_capture.sv
// Core trace capture: samples retired-instruction trace into a small record FIFO
// and serializes each record as a 3- or 4-word valid/ready stream.
module core_trace_capture #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        trace_commit,
    input  logic [31:0] trace_pc,
    input  logic [31:0] trace_instruction,
    input  logic        trace_exception,
    input  logic        trace_interrupt_fire,
    input  logic [2:0]  trace_mode,
    input  logic        trace_rd_wenx,
    input  logic [4:0]  trace_rd_waddr,
    input  logic [31:0] trace_rd_wdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        overflow,
    output logic [15:0] drop_count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);

    typedef struct packed {
        logic [15:0] seq;
        logic        exc;
        logic        irq;
        logic [2:0]  mode;
        logic        has_rd;
        logic [4:0]  waddr;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] wdata;
    } rec_t;

    typedef enum logic [2:0] {StIdle, StHdr, StPc, StInsn, StData} state_e;

    rec_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   seq_q;
    logic          overflow_q;
    logic [15:0]   drop_count_q;
    state_e        state_q, state_d;

    rec_t new_rec;
    rec_t head;
    logic full;
    logic push;
    logic pop;
    logic drop;

    assign head = mem_q[rd_ptr_q];
    assign full = (count_q == FullCount);

    // Final word of the head record accepted by the sink.
    assign pop = out_ready & ((state_q == StData) | ((state_q == StInsn) & ~head.has_rd));

    // A full FIFO still takes a commit when the head leaves in the same cycle.
    assign push = trace_commit & ~reset & (~full | pop);
    assign drop = trace_commit & ~reset & full & ~pop;

    assign count_d = count_q + CW'(push) - CW'(pop);

    // Pack the incoming commit into a record.
    always_comb begin
        new_rec        = '0;
        new_rec.seq    = seq_q;
        new_rec.exc    = trace_exception;
        new_rec.irq    = trace_interrupt_fire;
        new_rec.mode   = trace_mode;
        new_rec.has_rd = trace_rd_wenx & (trace_rd_waddr != 5'd0);
        new_rec.waddr  = trace_rd_waddr;
        new_rec.pc     = trace_pc;
        new_rec.insn   = trace_instruction;
        new_rec.wdata  = trace_rd_wdata;
    end

    // Record storage; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= new_rec;
        end
    end

    // FIFO pointers, sequence counter and drop accounting.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            seq_q        <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            // Sequence advances for stored and dropped commits alike.
            if (trace_commit) begin
                seq_q <= seq_q + 16'd1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_count_q != 16'hFFFF) begin
                    drop_count_q <= drop_count_q + 16'd1;
                end
            end
        end
    end

    // Serializer state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Serializer next state and stream outputs.
    always_comb begin
        state_d   = state_q;
        out_valid = 1'b0;
        out_data  = 32'd0;
        out_last  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    state_d = StHdr;
                end
            end
            StHdr: begin
                out_valid = 1'b1;
                out_data  = {head.seq, head.exc, head.irq, head.mode, head.has_rd,
                             head.waddr, 5'd0};
                if (out_ready) begin
                    state_d = StPc;
                end
            end
            StPc: begin
                out_valid = 1'b1;
                out_data  = head.pc;
                if (out_ready) begin
                    state_d = StInsn;
                end
            end
            StInsn: begin
                out_valid = 1'b1;
                out_data  = head.insn;
                out_last  = ~head.has_rd;
                if (out_ready) begin
                    if (head.has_rd) begin
                        state_d = StData;
                    end else begin
                        state_d = (count_d != '0) ? StHdr : StIdle;
                    end
                end
            end
            StData: begin
                out_valid = 1'b1;
                out_data  = head.wdata;
                out_last  = 1'b1;
                if (out_ready) begin
                    state_d = (count_d != '0) ? StHdr : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_core_trace_capture.sv
// Directed bench for core_trace_capture: table of single-record vectors plus
// hand-written sequences for backpressure, overflow, full/pop collision and reset.
module tb_core_trace_capture;

    logic        clock = 1'b0;
    logic        reset;
    logic        trace_commit;
    logic [31:0] trace_pc;
    logic [31:0] trace_instruction;
    logic        trace_exception;
    logic        trace_interrupt_fire;
    logic [2:0]  trace_mode;
    logic        trace_rd_wenx;
    logic [4:0]  trace_rd_waddr;
    logic [31:0] trace_rd_wdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        overflow;
    logic [15:0] drop_count;

    int errors = 0;
    int checks = 0;

    core_trace_capture #(.DEPTH(4)) dut (
        .clock               (clock),
        .reset               (reset),
        .trace_commit        (trace_commit),
        .trace_pc            (trace_pc),
        .trace_instruction   (trace_instruction),
        .trace_exception     (trace_exception),
        .trace_interrupt_fire(trace_interrupt_fire),
        .trace_mode          (trace_mode),
        .trace_rd_wenx       (trace_rd_wenx),
        .trace_rd_waddr      (trace_rd_waddr),
        .trace_rd_wdata      (trace_rd_wdata),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_data            (out_data),
        .out_last            (out_last),
        .overflow            (overflow),
        .drop_count          (drop_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] wdata;
        logic        wenx;
        logic [4:0]  rd;
        logic [2:0]  mode;
        logic        exc;
        logic        irq;
        logic [31:0] exp_hdr;
        int          n_words;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_fields(input logic [31:0] pc, input logic [31:0] insn,
                              input logic [31:0] wdata, input logic wenx,
                              input logic [4:0] rd, input logic [2:0] mode,
                              input logic exc, input logic irq);
        trace_pc             = pc;
        trace_instruction    = insn;
        trace_rd_wdata       = wdata;
        trace_rd_wenx        = wenx;
        trace_rd_waddr       = rd;
        trace_mode           = mode;
        trace_exception      = exc;
        trace_interrupt_fire = irq;
    endtask

    // Called just after a rising edge; one commit cycle, returns just after the next edge.
    task automatic do_commit(input logic [31:0] pc, input logic [31:0] insn,
                             input logic [31:0] wdata, input logic wenx,
                             input logic [4:0] rd, input logic [2:0] mode,
                             input logic exc, input logic irq);
        set_fields(pc, insn, wdata, wenx, rd, mode, exc, irq);
        trace_commit = 1'b1;
        @(posedge clock); #1;
        trace_commit = 1'b0;
    endtask

    // Cycle N+1 after a commit into an idle block: nothing on the stream yet.
    task automatic latency_gap();
        @(negedge clock);
        chk("latency_gap_valid", 32'(out_valid), 32'd0);
        @(posedge clock); #1;
    endtask

    // Expects a full record on consecutive cycles with out_ready held high.
    task automatic drain_record(input logic [31:0] hdr, input logic [31:0] pc,
                                input logic [31:0] insn, input logic [31:0] wdata,
                                input int n);
        logic [31:0] exp_w [4];
        exp_w[0] = hdr;
        exp_w[1] = pc;
        exp_w[2] = insn;
        exp_w[3] = wdata;
        for (int w = 0; w < n; w++) begin
            @(negedge clock);
            chk("rec_valid", 32'(out_valid), 32'd1);
            chk("rec_data", out_data, exp_w[w]);
            chk("rec_last", 32'(out_last), 32'(w == n - 1));
            @(posedge clock); #1;
        end
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        trace_commit = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_drop_count", 32'(drop_count), 32'd0);
        @(posedge clock); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bp_exp [4];
        int idx;

        // pc, insn, wdata, wenx, rd, mode, exc, irq, expected header, words
        vecs[0] = '{32'h8000_0000, 32'h00A0_0093, 32'h0000_000A, 1'b1, 5'd1, 3'd3,
                    1'b0, 1'b0, 32'h0000_1C20, 4};
        vecs[1] = '{32'h8000_0004, 32'h0000_0013, 32'h0000_0055, 1'b1, 5'd0, 3'd0,
                    1'b1, 1'b0, 32'h0001_8000, 3};
        vecs[2] = '{32'h8000_0008, 32'h0050_0293, 32'h0000_0077, 1'b0, 5'd5, 3'd7,
                    1'b0, 1'b1, 32'h0002_78A0, 3};
        vecs[3] = '{32'h8000_000C, 32'h0000_0FB7, 32'hDEAD_BEEF, 1'b1, 5'd31, 3'd1,
                    1'b1, 1'b1, 32'h0003_CFE0, 4};

        reset        = 1'b1;
        trace_commit = 1'b0;
        out_ready    = 1'b1;
        set_fields(32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        @(posedge clock); #1;
        do_reset();

        // Table of single records, each into an idle block.
        for (int v = 0; v < 4; v++) begin
            do_commit(vecs[v].pc, vecs[v].insn, vecs[v].wdata, vecs[v].wenx, vecs[v].rd,
                      vecs[v].mode, vecs[v].exc, vecs[v].irq);
            latency_gap();
            drain_record(vecs[v].exp_hdr, vecs[v].pc, vecs[v].insn, vecs[v].wdata,
                         vecs[v].n_words);
            @(negedge clock);
            chk("idle_after_record", 32'(out_valid), 32'd0);
            @(posedge clock); #1;
        end

        // Random backpressure across one 4-word record (seq 4).
        bp_exp[0] = 32'h0004_0440;
        bp_exp[1] = 32'h0000_0100;
        bp_exp[2] = 32'h0000_0200;
        bp_exp[3] = 32'h0000_1234;
        do_commit(32'h100, 32'h200, 32'h1234, 1'b1, 5'd2, 3'd0, 1'b0, 1'b0);
        latency_gap();
        idx = 0;
        for (int c = 0; c < 200 && idx < 4; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clock);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", out_data, bp_exp[idx]);
            chk("bp_last", 32'(out_last), 32'(idx == 3));
            if (out_ready) idx++;
            @(posedge clock); #1;
        end
        chk("bp_words_received", 32'(idx), 32'd4);
        out_ready = 1'b1;
        @(negedge clock);
        chk("bp_idle_after", 32'(out_valid), 32'd0);
        @(posedge clock); #1;

        // Overflow: six commits with the sink stalled, two dropped.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            do_commit(32'(i), 32'h1000 + 32'(i), 32'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        end
        @(negedge clock);
        chk("ovf_overflow", 32'(overflow), 32'd1);
        chk("ovf_drop_count", 32'(drop_count), 32'd2);
        @(posedge clock); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drain_record(32'(i) << 16, 32'(i), 32'h1000 + 32'(i), 32'd0, 3);
        end
        @(negedge clock);
        chk("ovf_drained", 32'(out_valid), 32'd0);
        @(posedge clock); #1;
        do_commit(32'h66, 32'h6666, 32'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        latency_gap();
        drain_record(32'h0006_0000, 32'h66, 32'h6666, 32'd0, 3);

        // Full FIFO with a commit coinciding with the final-word pop.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_commit(32'(i), 32'h1000 + 32'(i), 32'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clock);
        chk("col_hdr", out_data, 32'h0000_0000);
        @(posedge clock); #1;
        @(negedge clock);
        chk("col_pc", out_data, 32'h0000_0000);
        @(posedge clock); #1;
        set_fields(32'h44, 32'h4444, 32'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0);
        trace_commit = 1'b1;
        @(negedge clock);
        chk("col_insn", out_data, 32'h0000_1000);
        chk("col_last", 32'(out_last), 32'd1);
        @(posedge clock); #1;
        trace_commit = 1'b0;
        chk("col_overflow", 32'(overflow), 32'd0);
        chk("col_drop_count", 32'(drop_count), 32'd0);
        for (int i = 1; i < 4; i++) begin
            drain_record(32'(i) << 16, 32'(i), 32'h1000 + 32'(i), 32'd0, 3);
        end
        drain_record(32'h0004_0000, 32'h44, 32'h4444, 32'd0, 3);
        @(negedge clock);
        chk("col_drained", 32'(out_valid), 32'd0);
        @(posedge clock); #1;

        // Reset during the PC word, with a commit presented while in reset.
        do_commit(32'h300, 32'h301, 32'h7, 1'b1, 5'd3, 3'd2, 1'b0, 1'b0);
        latency_gap();
        @(negedge clock);
        chk("mid_hdr", out_data, 32'h0005_1460);
        @(posedge clock); #1;
        reset = 1'b1;
        trace_commit = 1'b1;
        @(negedge clock);
        chk("mid_pc", out_data, 32'h0000_0300);
        @(posedge clock); #1;
        @(negedge clock);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", out_data, 32'd0);
        chk("mid_rst_last", 32'(out_last), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        trace_commit = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            chk("mid_quiet", 32'(out_valid), 32'd0);
            @(posedge clock); #1;
        end
        do_commit(32'h300, 32'h301, 32'h7, 1'b1, 5'd3, 3'd2, 1'b0, 1'b0);
        latency_gap();
        drain_record(32'h0000_1460, 32'h300, 32'h301, 32'h7, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/core_trace_capture.md
CORE_TRACE_CAPTURE -- requirements
Module: core_trace_capture

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of commit records buffered (power of two, 2..16).
REQ-002 Port clock, input, 1, meaning the single clock for all logic.
REQ-003 Port reset, input, 1, meaning a synchronous, active-high reset.
REQ-004 Port trace_commit, input, 1, meaning an instruction is retired this cycle.
REQ-005 Port trace_pc, input, 32, meaning the retired instruction address.
REQ-006 Port trace_instruction, input, 32, meaning the retired instruction word.
REQ-007 Port trace_exception, input, 1, meaning an exception occurred.
REQ-008 Port trace_interrupt_fire, input, 1, meaning an interrupt was taken.
REQ-009 Port trace_mode, input, 3, meaning the privilege/debug mode.
REQ-010 Port trace_rd_wenx, input, 1, meaning an integer rd write.
REQ-011 Port trace_rd_waddr, input, 5, meaning the rd number.
REQ-012 Port trace_rd_wdata, input, 32, meaning the rd write data.
REQ-013 Port out_valid, output, 1, meaning out_data holds a valid stream word.
REQ-014 Port out_ready, input, 1, meaning the sink accepts the word.
REQ-015 Port out_data, output, 32, meaning the stream word.
REQ-016 Port out_last, output, 1, meaning this is the final word of a record.
REQ-017 Port overflow, output, 1, meaning sticky: at least one record was dropped.
REQ-018 Port drop_count, output, 16, meaning the number of dropped records, saturating.

Function
REQ-019 Sampling: on each cycle with trace_commit=1, the block SHALL capture all trace_* inputs, together with the current seq value, into one FIFO record.
REQ-020 Sequence counter: seq is 16 bits, SHALL increment on every commit whether the record is stored or dropped, and SHALL wrap from 0xFFFF to 0x0000.
REQ-021 has_rd SHALL be defined as trace_rd_wenx AND (trace_rd_waddr != 0).
REQ-022 Header word SHALL be laid out as follows:
- [31:16] seq
- [15] exception
- [14] interrupt_fire
- [13:11] mode
- [10] has_rd
- [9:5] rd_waddr
- [4:0] zero
REQ-023 Record word order SHALL be header, pc, instruction, then rd_wdata only when has_rd=1; out_last SHALL be 1 on the final word (the 3rd or 4th).
REQ-024 The serializer FSM SHALL have states IDLE, HDR, PC, INSN and DATA.
REQ-025 FSM transitions:
- IDLE->HDR when the FIFO is non-empty.
- HDR->PC, PC->INSN, and INSN->DATA (when has_rd) each occur only on out_valid & out_ready.
- The final word accepted SHALL pop the FIFO; the FSM then goes to HDR if the FIFO is still non-empty after the pop, else IDLE.
REQ-026 out_valid SHALL be 1 exactly in states HDR, PC, INSN and DATA.
REQ-027 out_data and out_last SHALL be stable while out_valid=1 and out_ready=0.
REQ-028 Latency: a commit in cycle N into an empty FIFO with the FSM in IDLE SHALL present the header with out_valid=1 in cycle N+2 (cycle N+1 write, N+2 FSM in HDR).
REQ-029 Back-to-back records SHALL have zero bubble: the word after an accepted out_last is the next header in the following cycle if the FIFO is non-empty.
REQ-030 Full FIFO: a commit when the FIFO is full and there is no simultaneous pop SHALL be dropped, SHALL set overflow=1, and SHALL increment drop_count (saturating at 0xFFFF).
REQ-031 A commit in the same cycle as the final-word pop of a full FIFO SHALL be stored, not dropped.
REQ-032 Commits SHALL be accepted at one per cycle with no input backpressure.

Reset
REQ-033 While reset=1 at a clock edge, the following SHALL happen:
- FIFO emptied
- FSM set to IDLE
- seq=0, overflow=0, drop_count=0
- out_valid=0, out_last=0, out_data=0 from the next cycle
REQ-034 A commit in a cycle with reset=1 SHALL be ignored.
REQ-035 Reset asserted mid-record SHALL abandon the record with no further words emitted.
REQ-036 The first commit after reset SHALL carry seq=0.

Verification
REQ-037 Single commit: pc=0x80000000, instr=0x00A00093, rd_wenx=1, rd=1, wdata=0xA, mode=3, out_ready=1 -> in cycles N+2..N+5 the words are 0x00001C20 (mode=3, has_rd=1, rd=1), 0x80000000, 0x00A00093, 0x0000000A, with out_last on the 4th.
REQ-038 rd=x0 write: rd_wenx=1, rd_waddr=0 -> has_rd=0, 3 words, out_last on the instruction word.
REQ-039 Overflow: DEPTH=4, out_ready=0, 6 commits -> 4 stored (seq 0..3), overflow=1, drop_count=2; then out_ready=1 drains seq 0,1,2,3 in order, and the next commit carries seq=6.
REQ-040 Backpressure: toggle out_ready randomly during a record -> out_data is held stable while stalled, and no word is lost or duplicated.
REQ-041 Full plus pop collision: FIFO full, commit in the same cycle as the final-word accept -> record stored, overflow stays 0.
REQ-042 Reset mid-record: assert reset during the PC word -> next cycle out_valid=0; after reset, a commit yields header seq=0.
